// File: rtl/ex_mem_elastic_reg.sv
// Elastic pipeline stage between EX and MEM with valid/ready handshake.
// The main entry M feeds the outputs. An optional skid entry S lets in_ready
// come from a flop. Also provides flush, occupancy and a saturating stall counter.
module ex_mem_elastic_reg #(
    parameter int                 CTRL_W      = 6,
    parameter logic [CTRL_W-1:0]  CTRL_RST    = {CTRL_W{1'b0}},
    parameter int                 DATA_W      = 161,
    parameter int                 SKID        = 1,
    parameter int                 STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [CTRL_W-1:0]      in_ctrl,
    input  logic [DATA_W-1:0]      in_data,
    input  logic                   flush,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [CTRL_W-1:0]      out_ctrl,
    output logic [DATA_W-1:0]      out_data,
    output logic [1:0]             level,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    // The encoding doubles as the occupancy count.
    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [CTRL_W-1:0]       m_ctrl_q, m_ctrl_d, s_ctrl_q, s_ctrl_d;
    logic [DATA_W-1:0]       m_data_q, m_data_d, s_data_q, s_data_d;
    logic                    in_ready_q, in_ready_d;
    logic [STALL_CNT_W-1:0]  stall_q, stall_d;
    logic                    in_fire, out_fire;

    // Handshake and output decode. With SKID = 0 the stage accepts a word
    // whenever the head is leaving in the same cycle.
    always_comb begin
        out_valid = (state_q != S_EMPTY);
        in_ready  = (SKID != 0) ? in_ready_q : (!out_valid || out_ready);
        in_fire   = in_valid && in_ready;
        out_fire  = out_valid && out_ready;
        out_ctrl  = out_valid ? m_ctrl_q : CTRL_RST;
        out_data  = m_data_q;
        level     = state_q;
        stall_cnt = stall_q;
    end

    // Next-state and datapath. Flush overrides everything. It leaves the data
    // registers alone; the masked control field already marks them dead.
    always_comb begin
        state_d  = state_q;
        m_ctrl_d = m_ctrl_q;
        m_data_d = m_data_q;
        s_ctrl_d = s_ctrl_q;
        s_data_d = s_data_q;
        if (flush) begin
            state_d  = S_EMPTY;
            m_ctrl_d = CTRL_RST;
            s_ctrl_d = CTRL_RST;
        end else begin
            case (state_q)
                S_EMPTY: begin
                    if (in_fire) begin
                        state_d  = S_ONE;
                        m_ctrl_d = in_ctrl;
                        m_data_d = in_data;
                    end
                end
                S_ONE: begin
                    if (in_fire && (out_fire || SKID == 0)) begin
                        // Head leaves as the new word arrives. Without a skid
                        // entry in_ready implies out_ready, so this is the only case.
                        m_ctrl_d = in_ctrl;
                        m_data_d = in_data;
                    end else if (in_fire) begin
                        state_d  = S_TWO;
                        s_ctrl_d = in_ctrl;
                        s_data_d = in_data;
                    end else if (out_fire) begin
                        state_d  = S_EMPTY;
                        m_ctrl_d = CTRL_RST;
                    end
                end
                S_TWO: begin
                    if (out_fire) begin
                        state_d  = S_ONE;
                        m_ctrl_d = s_ctrl_q;
                        m_data_d = s_data_q;
                        s_ctrl_d = CTRL_RST;
                    end
                end
                default: begin
                    state_d  = S_EMPTY;
                    m_ctrl_d = CTRL_RST;
                    s_ctrl_d = CTRL_RST;
                end
            endcase
        end
        in_ready_d = (state_d != S_TWO);
    end

    // Saturating count of stalled cycles; only reset clears it.
    always_comb begin
        stall_d = stall_q;
        if (out_valid && !out_ready && !(&stall_q))
            stall_d = stall_q + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_EMPTY;
            m_ctrl_q   <= CTRL_RST;
            m_data_q   <= '0;
            s_ctrl_q   <= CTRL_RST;
            s_data_q   <= '0;
            in_ready_q <= 1'b1;
            stall_q    <= '0;
        end else begin
            state_q    <= state_d;
            m_ctrl_q   <= m_ctrl_d;
            m_data_q   <= m_data_d;
            s_ctrl_q   <= s_ctrl_d;
            s_data_q   <= s_data_d;
            in_ready_q <= in_ready_d;
            stall_q    <= stall_d;
        end
    end

endmodule

// File: tb/tb_ex_mem_elastic_reg.sv
// Bench for ex_mem_elastic_reg. It runs three instances: SKID=1, SKID=0,
// and SKID=1 with a 4-bit stall counter. A queue-level reference model
// covers all three, plus directed scenarios with literal expectations.
module tb_ex_mem_elastic_reg;

    typedef struct packed {
        logic [5:0]   c;
        logic [160:0] d;
    } word_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic         iv[3], fl[3], ordy[3];
    logic [5:0]   ic[3];
    logic [160:0] id[3];
    logic         o_v[3], o_r[3];
    logic [5:0]   o_c[3];
    logic [160:0] o_d[3];
    logic [1:0]   o_l[3];
    logic [15:0]  o_s0, o_s1;
    logic [3:0]   o_s2;
    logic [15:0]  o_s[3];
    assign o_s[0] = o_s0;
    assign o_s[1] = o_s1;
    assign o_s[2] = {12'd0, o_s2};

    ex_mem_elastic_reg #(.SKID(1)) u_s1 (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(o_r[0]), .in_ctrl(ic[0]),
        .in_data(id[0]), .flush(fl[0]), .out_valid(o_v[0]), .out_ready(ordy[0]),
        .out_ctrl(o_c[0]), .out_data(o_d[0]), .level(o_l[0]), .stall_cnt(o_s0));
    ex_mem_elastic_reg #(.SKID(0)) u_s0 (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(o_r[1]), .in_ctrl(ic[1]),
        .in_data(id[1]), .flush(fl[1]), .out_valid(o_v[1]), .out_ready(ordy[1]),
        .out_ctrl(o_c[1]), .out_data(o_d[1]), .level(o_l[1]), .stall_cnt(o_s1));
    ex_mem_elastic_reg #(.SKID(1), .STALL_CNT_W(4)) u_sat (
        .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(o_r[2]), .in_ctrl(ic[2]),
        .in_data(id[2]), .flush(fl[2]), .out_valid(o_v[2]), .out_ready(ordy[2]),
        .out_ctrl(o_c[2]), .out_data(o_d[2]), .level(o_l[2]), .stall_cnt(o_s2));

    // Reference model: each stage is a FIFO of at most two (or one) words.
    int    n_cmp = 0, n_bad = 0;
    word_t mw[3][2];
    int    mn[3];
    int    ms[3];
    int    skid[3] = '{1, 0, 1};
    int    smax[3] = '{65535, 65535, 15};

    task automatic chk(input string nm, input logic [191:0] act, input logic [191:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic exp_ir(input int i);
        return (skid[i] != 0) ? (mn[i] < 2) : (mn[i] == 0 || ordy[i]);
    endfunction

    function automatic word_t rw();
        logic [191:0] r;
        word_t w;
        r = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        w.c = r[191:186];
        w.d = r[160:0];
        return w;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            mn[i] = 0;
            ms[i] = 0;
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("u%0d.out_valid", i), 192'(o_v[i]), 192'(mn[i] > 0));
            chk($sformatf("u%0d.in_ready", i), 192'(o_r[i]), 192'(exp_ir(i)));
            chk($sformatf("u%0d.level", i), 192'(o_l[i]), 192'(mn[i]));
            chk($sformatf("u%0d.stall_cnt", i), 192'(o_s[i]), 192'(ms[i]));
            chk($sformatf("u%0d.out_ctrl", i), 192'(o_c[i]), (mn[i] > 0) ? 192'(mw[i][0].c) : 192'd0);
            if (mn[i] > 0)
                chk($sformatf("u%0d.out_data", i), 192'(o_d[i]), 192'(mw[i][0].d));
        end
    endtask

    task automatic model_update();
        for (int i = 0; i < 3; i++) begin
            logic inf, outf;
            inf  = iv[i] && exp_ir(i);
            outf = (mn[i] > 0) && ordy[i];
            if (mn[i] > 0 && !ordy[i] && ms[i] != smax[i]) ms[i]++;
            if (fl[i]) mn[i] = 0;
            else begin
                if (outf) begin
                    mw[i][0] = mw[i][1];
                    mn[i]--;
                end
                if (inf) begin
                    mw[i][mn[i]].c = ic[i];
                    mw[i][mn[i]].d = id[i];
                    mn[i]++;
                end
            end
        end
    endtask

    // Called at a falling edge with inputs set; returns at the next falling edge.
    task automatic step();
        #1;
        check_all();
        model_update();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_in(input int i, input word_t w);
        ic[i] = w.c;
        id[i] = w.d;
    endtask

    task automatic idle_all();
        for (int i = 0; i < 3; i++) begin
            iv[i] = 1'b0; fl[i] = 1'b0; ordy[i] = 1'b1;
            ic[i] = '0;   id[i] = '0;
        end
    endtask

    task automatic rand_all();
        for (int i = 0; i < 3; i++) begin
            iv[i]   = ($urandom_range(0, 9) < 7);
            ordy[i] = ($urandom_range(0, 9) < 6);
            fl[i]   = ($urandom_range(0, 19) == 0);
            set_in(i, rw());
        end
    endtask

    word_t wa, wb, wc, wd, we;
    word_t got[$];

    initial begin
        model_reset();
        idle_all();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        // Reset values.
        chk("rst.out_valid", 192'(o_v[0]), 192'd0);
        chk("rst.level", 192'(o_l[0]), 192'd0);
        chk("rst.stall_cnt", 192'(o_s[0]), 192'd0);
        chk("rst.in_ready", 192'(o_r[0]), 192'd1);
        chk("rst.out_ctrl", 192'(o_c[0]), 192'd0);
        chk("rst.out_data", 192'(o_d[0]), 192'd0);
        @(negedge clk);

        // Streaming: 8 back-to-back words.
        for (int k = 0; k < 8; k++) begin
            iv[0] = 1'b1;
            set_in(0, rw());
            step();
            chk("stream.level", 192'(o_l[0]), 192'd1);
            chk("stream.in_ready", 192'(o_r[0]), 192'd1);
        end
        iv[0] = 1'b0;
        step();

        // Back-pressure: A, B and C offered while out_ready is low.
        wa = rw(); wb = rw(); wc = rw();
        ordy[0] = 1'b0;
        iv[0] = 1'b1; set_in(0, wa); step();
        set_in(0, wb); step();
        set_in(0, wc);
        repeat (4) step();
        chk("bp.stall_cnt", 192'(o_s[0]), 192'd5);
        chk("bp.level", 192'(o_l[0]), 192'd2);
        chk("bp.in_ready", 192'(o_r[0]), 192'd0);
        chk("bp.head", 192'(o_d[0]), 192'(wa.d));
        ordy[0] = 1'b1;
        for (int k = 0; k < 8; k++) begin
            logic acc;
            if (o_v[0]) got.push_back(word_t'({o_c[0], o_d[0]}));
            acc = iv[0] && o_r[0];
            step();
            if (acc) iv[0] = 1'b0;
        end
        chk("bp.count", 192'(got.size()), 192'd3);
        if (got.size() == 3) begin
            chk("bp.out0", 192'(got[0]), 192'(wa));
            chk("bp.out1", 192'(got[1]), 192'(wb));
            chk("bp.out2", 192'(got[2]), 192'(wc));
        end

        // Flush while in TWO and while D is offered.
        ordy[0] = 1'b0;
        iv[0] = 1'b1; set_in(0, rw()); step();
        set_in(0, rw()); step();
        wd = rw();
        fl[0] = 1'b1; set_in(0, wd); step();
        fl[0] = 1'b0; iv[0] = 1'b0;
        chk("fl.level", 192'(o_l[0]), 192'd0);
        chk("fl.out_valid", 192'(o_v[0]), 192'd0);
        chk("fl.out_ctrl", 192'(o_c[0]), 192'd0);
        we = rw();
        ordy[0] = 1'b1; iv[0] = 1'b1; set_in(0, we); step();
        iv[0] = 1'b0;
        chk("fl.after_v", 192'(o_v[0]), 192'd1);
        chk("fl.after_d", 192'(o_d[0]), 192'(we.d));
        step();

        // Asynchronous reset pulse between edges with level = 2.
        ordy[0] = 1'b0;
        iv[0] = 1'b1; set_in(0, rw()); step();
        set_in(0, rw()); step();
        iv[0] = 1'b0;
        chk("ar.pre_level", 192'(o_l[0]), 192'd2);
        #1 rst = 1'b1;
        #1;
        chk("ar.out_valid", 192'(o_v[0]), 192'd0);
        chk("ar.level", 192'(o_l[0]), 192'd0);
        chk("ar.stall_cnt", 192'(o_s[0]), 192'd0);
        chk("ar.in_ready", 192'(o_r[0]), 192'd1);
        rst = 1'b0;
        model_reset();
        idle_all();
        step();

        // SKID = 0: in_ready follows out_ready combinationally while full.
        ordy[1] = 1'b0; iv[1] = 1'b1; set_in(1, rw()); step();
        #1;
        chk("s0.in_ready_lo", 192'(o_r[1]), 192'd0);
        ordy[1] = 1'b1; set_in(1, rw());
        #1;
        chk("s0.in_ready_hi", 192'(o_r[1]), 192'd1);
        step();
        iv[1] = 1'b0;
        step();

        // Stall counter saturation on the 4-bit instance.
        iv[2] = 1'b1; ordy[2] = 1'b0; set_in(2, rw()); step();
        iv[2] = 1'b0;
        repeat (20) step();
        chk("sat.cnt", 192'(o_s[2]), 192'd15);
        step();
        chk("sat.hold", 192'(o_s[2]), 192'd15);
        ordy[2] = 1'b1;
        step();

        // Randomised traffic on all three instances.
        for (int k = 0; k < 800; k++) begin
            rand_all();
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
